// File: rtl/pdp8_bus_responder.sv
// Memory/IO responder for the PDP-8 multiplexed nibble bus: decodes the beat stream, returns read
// nibbles combinationally, commits 12-bit writes to an internal RAM or to a single device port.
module pdp8_bus_responder #(
    parameter int MEM_AW = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        bus_in,
    output logic [3:0]        data_out,
    input  logic              ld_we,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [11:0]       ld_data,
    input  logic [11:0]       dev_rdata,
    input  logic              dev_ready,
    input  logic              dev_skip,
    input  logic              dev_int,
    output logic              dev_we,
    output logic [5:0]        dev_addr,
    output logic [2:0]        dev_op,
    output logic [11:0]       dev_wdata,
    output logic              err
);

    typedef enum logic [2:0] {
        S_ALO  = 3'd0,
        S_AHI  = 3'd1,
        S_IOD0 = 3'd2,
        S_D1   = 3'd3,
        S_D2   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic        io_q, io_d;
    logic [11:0] rword_q, rword_d;
    logic [11:0] wword_q, wword_d;
    logic        err_q, err_d;
    logic        dev_we_q, dev_we_d;
    logic [5:0]  dev_addr_q, dev_addr_d;
    logic [2:0]  dev_op_q, dev_op_d;
    logic [11:0] dev_wdata_q, dev_wdata_d;

    logic [11:0] mem [2**MEM_AW];
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] raddr_full;

    logic       is_alo, is_ahi, is_io, is_d0, is_d1, is_d2, beat_w;
    logic [3:0] beat_d;

    always_comb begin
        is_alo = (bus_in[7:6] == 2'b10);
        is_ahi = (bus_in[7:6] == 2'b11);
        is_io  = (bus_in[7:5] == 3'b011) && !bus_in[3];
        is_d0  = (bus_in[7:5] == 3'b000);
        is_d1  = (bus_in[7:5] == 3'b001);
        is_d2  = (bus_in[7:5] == 3'b010);
        beat_w = bus_in[4];
        beat_d = bus_in[3:0];
    end

    // Zero-latency return path: depends only on the current beat, never on state.
    always_comb begin
        data_out = 4'h0;
        if (is_io)
            data_out = {1'b0, dev_int, dev_skip, dev_ready};
        else if (is_d0 && !beat_w)
            data_out = rword_q[11:8];
        else if (is_d1 && !beat_w)
            data_out = rword_q[7:4];
        else if (is_d2 && !beat_w)
            data_out = rword_q[3:0];
    end

    assign raddr_full = {bus_in[5:0], addr_q[5:0]};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        io_d        = io_q;
        rword_d     = rword_q;
        wword_d     = wword_q;
        err_d       = err_q;
        dev_we_d    = 1'b0;
        dev_addr_d  = dev_addr_q;
        dev_op_d    = dev_op_q;
        dev_wdata_d = dev_wdata_q;
        mem_we      = 1'b0;
        mem_wdata   = {beat_d, wword_q[7:0]};

        if (state_q != S_ALO && is_alo) begin
            // Resync: drop the partial transaction and treat this as a fresh address.
            err_d       = 1'b1;
            io_d        = 1'b0;
            addr_d[5:0] = bus_in[5:0];
            state_d     = S_AHI;
        end else begin
            case (state_q)
                S_ALO: begin
                    if (is_alo) begin
                        addr_d[5:0] = bus_in[5:0];
                        state_d     = S_AHI;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_AHI: begin
                    if (is_ahi) begin
                        addr_d[11:6] = bus_in[5:0];
                        rword_d      = mem[raddr_full[MEM_AW-1:0]];
                        state_d      = S_IOD0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ALO;
                    end
                end
                S_IOD0: begin
                    if (is_io && !io_q) begin
                        io_d     = 1'b1;
                        dev_op_d = bus_in[2:0];
                        rword_d  = dev_rdata;
                    end else if (is_d0) begin
                        if (beat_w)
                            wword_d[3:0] = beat_d;
                        state_d = S_D1;
                    end else begin
                        err_d   = 1'b1;
                        io_d    = 1'b0;
                        state_d = S_ALO;
                    end
                end
                S_D1: begin
                    if (is_d1) begin
                        if (beat_w)
                            wword_d[7:4] = beat_d;
                        state_d = S_D2;
                    end else begin
                        err_d   = 1'b1;
                        io_d    = 1'b0;
                        state_d = S_ALO;
                    end
                end
                S_D2: begin
                    io_d    = 1'b0;
                    state_d = S_ALO;
                    if (is_d2) begin
                        if (beat_w && io_q) begin
                            dev_wdata_d = {beat_d, wword_q[7:0]};
                            dev_addr_d  = addr_q[5:0];
                            dev_we_d    = 1'b1;
                        end else if (beat_w) begin
                            mem_we = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_ALO;
                    io_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_ALO;
            addr_q      <= 12'h000;
            io_q        <= 1'b0;
            rword_q     <= 12'h000;
            wword_q     <= 12'h000;
            err_q       <= 1'b0;
            dev_we_q    <= 1'b0;
            dev_addr_q  <= 6'h00;
            dev_op_q    <= 3'h0;
            dev_wdata_q <= 12'h000;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            io_q        <= io_d;
            rword_q     <= rword_d;
            wword_q     <= wword_d;
            err_q       <= err_d;
            dev_we_q    <= dev_we_d;
            dev_addr_q  <= dev_addr_d;
            dev_op_q    <= dev_op_d;
            dev_wdata_q <= dev_wdata_d;
        end
    end

    // Bus write is ordered after the preload so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (ld_we)
            mem[ld_addr] <= ld_data;
        if (mem_we)
            mem[addr_q[MEM_AW-1:0]] <= mem_wdata;
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q, raddr_full};

    assign dev_we    = dev_we_q;
    assign dev_addr  = dev_addr_q;
    assign dev_op    = dev_op_q;
    assign dev_wdata = dev_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pdp8_bus_responder.sv
// Directed bench for pdp8_bus_responder: memory read/write, aliasing, IO read/write, resync, async reset.
module tb_pdp8_bus_responder;

    localparam int MEM_AW = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        bus_in;
    logic [3:0]        data_out;
    logic              ld_we;
    logic [MEM_AW-1:0] ld_addr;
    logic [11:0]       ld_data;
    logic [11:0]       dev_rdata;
    logic              dev_ready, dev_skip, dev_int;
    logic              dev_we;
    logic [5:0]        dev_addr;
    logic [2:0]        dev_op;
    logic [11:0]       dev_wdata;
    logic              err;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    pdp8_bus_responder #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .data_out(data_out),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .dev_rdata(dev_rdata), .dev_ready(dev_ready), .dev_skip(dev_skip), .dev_int(dev_int),
        .dev_we(dev_we), .dev_addr(dev_addr), .dev_op(dev_op), .dev_wdata(dev_wdata), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dev_we === 1'b1) we_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Present one beat for a full cycle, capture data_out mid-cycle, return at edge+1.
    task automatic send_beat(input logic [7:0] b, output logic [3:0] dout);
        bus_in = b;
        @(negedge clk);
        dout = data_out;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [MEM_AW-1:0] a, input logic [11:0] w);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = w;
        @(posedge clk);
        #1;
        ld_we   = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (dev_we !== 1'b0) begin errors++; $display("FAIL reset_dev_we: got %b expected 0", dev_we); end
        checks++; if (dev_addr !== 6'h00) begin errors++; $display("FAIL reset_dev_addr: got %h expected 00", dev_addr); end
        checks++; if (dev_op !== 3'h0) begin errors++; $display("FAIL reset_dev_op: got %h expected 0", dev_op); end
        checks++; if (dev_wdata !== 12'h000) begin errors++; $display("FAIL reset_dev_wdata: got %h expected 000", dev_wdata); end
        bus_in = 8'h80; #1;
        checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL reset_dout_alo: got %h expected 0", data_out); end
        bus_in = 8'hC5; #1;
        checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL reset_dout_ahi: got %h expected 0", data_out); end
        bus_in = 8'h00; #1;
        checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL reset_rword: got %h expected 0", data_out); end
    endtask

    task automatic test_preload_read();
        logic [3:0] d;
        logic [7:0] beats [5] = '{8'h85, 8'hC0, 8'h00, 8'h20, 8'h40};
        logic [3:0] exp_n [3] = '{4'hA, 4'hB, 4'hC};
        send_beat(beats[0], d);
        send_beat(beats[1], d);
        for (int i = 0; i < 3; i++) begin
            send_beat(beats[2+i], d);
            checks++;
            if (d !== exp_n[i]) begin errors++; $display("FAIL preload_read nibble %0d: got %h expected %h", i, d, exp_n[i]); end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL preload_read_err: got %b expected 0", err); end
    endtask

    task automatic test_write_readback();
        logic [3:0] d;
        logic [7:0] wr [5] = '{8'h87, 8'hC1, 8'h13, 8'h32, 8'h51};
        logic [7:0] rd [5] = '{8'h87, 8'hC1, 8'h00, 8'h20, 8'h40};
        logic [7:0] al [5] = '{8'h87, 8'hC0, 8'h00, 8'h20, 8'h40};
        logic [3:0] exp_n [3] = '{4'h1, 4'h2, 4'h3};
        for (int i = 0; i < 5; i++) begin
            send_beat(wr[i], d);
            if (i >= 2) begin
                checks++;
                if (d !== 4'h0) begin errors++; $display("FAIL write_beat_dout %0d: got %h expected 0", i, d); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            send_beat(rd[i], d);
            if (i >= 2) begin
                checks++;
                if (d !== exp_n[i-2]) begin errors++; $display("FAIL readback nibble %0d: got %h expected %h", i-2, d, exp_n[i-2]); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            send_beat(al[i], d);
            if (i >= 2) begin
                checks++;
                if (d !== exp_n[i-2]) begin errors++; $display("FAIL alias nibble %0d: got %h expected %h", i-2, d, exp_n[i-2]); end
            end
        end
        checks++; if (dev_we !== 1'b0) begin errors++; $display("FAIL write_no_dev_we: got %b expected 0", dev_we); end
    endtask

    task automatic test_io_read();
        logic [3:0] d;
        logic [7:0] beats [4] = '{8'h64, 8'h00, 8'h20, 8'h40};
        logic [3:0] exp_n [4] = '{4'h5, 4'h5, 4'hA, 4'h6};
        logic [7:0] rd [5] = '{8'h83, 8'hC0, 8'h00, 8'h20, 8'h40};
        int w0;
        w0 = we_cnt;
        dev_ready = 1'b1; dev_skip = 1'b0; dev_int = 1'b1; dev_rdata = 12'h5A6;
        send_beat(8'h83, d);
        send_beat(8'hC0, d);
        for (int i = 0; i < 4; i++) begin
            send_beat(beats[i], d);
            checks++;
            if (d !== exp_n[i]) begin errors++; $display("FAIL io_read beat %0d: got %h expected %h", i, d, exp_n[i]); end
        end
        checks++; if (dev_op !== 3'h4) begin errors++; $display("FAIL io_read_op: got %h expected 4", dev_op); end
        dev_rdata = 12'h000;
        for (int i = 0; i < 5; i++) begin
            send_beat(rd[i], d);
            if (i >= 2) begin
                checks++;
                if (d !== 4'h7) begin errors++; $display("FAIL io_read_ram nibble %0d: got %h expected 7", i-2, d); end
            end
        end
        checks++; if (we_cnt !== w0) begin errors++; $display("FAIL io_read_no_we: got %0d pulses expected 0", we_cnt - w0); end
    endtask

    task automatic test_io_write();
        logic [3:0] d;
        logic [7:0] beats [6] = '{8'h83, 8'hC0, 8'h72, 8'h11, 8'h3E, 8'h59};
        for (int i = 0; i < 5; i++) send_beat(beats[i], d);
        checks++; if (dev_we !== 1'b0) begin errors++; $display("FAIL io_write_early_we: got %b expected 0", dev_we); end
        send_beat(beats[5], d);
        checks++; if (dev_we !== 1'b1) begin errors++; $display("FAIL io_write_we: got %b expected 1", dev_we); end
        checks++; if (dev_addr !== 6'h03) begin errors++; $display("FAIL io_write_addr: got %h expected 03", dev_addr); end
        checks++; if (dev_op !== 3'h2) begin errors++; $display("FAIL io_write_op: got %h expected 2", dev_op); end
        checks++; if (dev_wdata !== 12'h9E1) begin errors++; $display("FAIL io_write_wdata: got %h expected 9e1", dev_wdata); end
    endtask

    // Starts immediately after the IO write's D2 edge, with no idle cycle.
    task automatic test_back_to_back(input int w_before);
        logic [3:0] d;
        logic [7:0] rd [5] = '{8'h83, 8'hC0, 8'h00, 8'h20, 8'h40};
        for (int i = 0; i < 5; i++) begin
            send_beat(rd[i], d);
            if (i == 0) begin
                checks++;
                if (dev_we !== 1'b0) begin errors++; $display("FAIL b2b_we_drop: got %b expected 0", dev_we); end
            end
            if (i >= 2) begin
                checks++;
                if (d !== 4'h7) begin errors++; $display("FAIL b2b_ram_untouched nibble %0d: got %h expected 7", i-2, d); end
            end
        end
        checks++; if (we_cnt - w_before !== 1) begin errors++; $display("FAIL b2b_we_pulses: got %0d expected 1", we_cnt - w_before); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", err); end
    endtask

    task automatic test_resync();
        logic [3:0] d;
        logic [7:0] rd [4] = '{8'hC0, 8'h00, 8'h20, 8'h40};
        logic [3:0] exp_n [3] = '{4'h4, 4'h5, 4'h6};
        send_beat(8'h81, d);
        send_beat(8'hC0, d);
        send_beat(8'h1F, d);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL resync_pre_err: got %b expected 0", err); end
        send_beat(8'h81, d);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL resync_err: got %b expected 1", err); end
        for (int i = 0; i < 4; i++) begin
            send_beat(rd[i], d);
            if (i >= 1) begin
                checks++;
                if (d !== exp_n[i-1]) begin errors++; $display("FAIL resync_read nibble %0d: got %h expected %h", i-1, d, exp_n[i-1]); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] d;
        logic [7:0] rd [5] = '{8'h85, 8'hC0, 8'h00, 8'h20, 8'h40};
        logic [3:0] exp_n [3] = '{4'hA, 4'hB, 4'hC};
        send_beat(8'h85, d);
        send_beat(8'hC0, d);
        send_beat(8'h11, d);
        send_beat(8'h32, d);
        bus_in = 8'h40;
        #1;
        reset = 1'b1;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL areset_err: got %b expected 0", err); end
        checks++; if (dev_wdata !== 12'h000) begin errors++; $display("FAIL areset_wdata: got %h expected 000", dev_wdata); end
        checks++; if (dev_addr !== 6'h00) begin errors++; $display("FAIL areset_addr: got %h expected 00", dev_addr); end
        checks++; if (dev_op !== 3'h0) begin errors++; $display("FAIL areset_op: got %h expected 0", dev_op); end
        checks++; if (dev_we !== 1'b0) begin errors++; $display("FAIL areset_we: got %b expected 0", dev_we); end
        checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL areset_rword: got %h expected 0", data_out); end
        bus_in = 8'h53;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_beat(rd[i], d);
            if (i >= 2) begin
                checks++;
                if (d !== exp_n[i-2]) begin errors++; $display("FAIL areset_target nibble %0d: got %h expected %h", i-2, d, exp_n[i-2]); end
            end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL areset_post_err: got %b expected 0", err); end
    endtask

    initial begin
        int w_before;
        reset = 1'b1;
        bus_in = 8'h80;
        ld_we = 1'b0; ld_addr = '0; ld_data = 12'h000;
        dev_rdata = 12'h000; dev_ready = 1'b0; dev_skip = 1'b0; dev_int = 1'b0;
        @(posedge clk);
        #1;
        preload(6'd5, 12'hABC);
        preload(6'd3, 12'h777);
        preload(6'd1, 12'h456);
        test_reset();
        reset = 1'b0;
        test_preload_read();
        test_write_readback();
        test_io_read();
        w_before = we_cnt;
        test_io_write();
        test_back_to_back(w_before);
        test_resync();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
